// File: rtl/rh11_pkg.sv
// Shared constants for the RH-11 NPR DMA engine: ARM register map, ID word,
// Unibus control-line codes and the bus-tenure state encoding.
package rh11_pkg;

    localparam logic [3:0] REG_ID   = 4'd0;
    localparam logic [3:0] REG_ADDR = 4'd1;
    localparam logic [3:0] REG_CTRL = 4'd2;
    localparam logic [3:0] REG_FIFO = 4'd3;
    localparam logic [3:0] REG_CLR  = 4'd4;

    localparam logic [31:0] RH_ID = 32'h4E50_5201;

    localparam logic [1:0] C_DATI = 2'b00;
    localparam logic [1:0] C_DATO = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_SACK    = 3'd2,
        S_SETUP   = 3'd3,
        S_MSYN    = 3'd4,
        S_WAITS   = 3'd5,
        S_RELEASE = 3'd6
    } npr_state_e;

endpackage

// File: rtl/rh11_wfifo.sv
// Synchronous 16-bit word FIFO between the ARM and the Unibus side.
// A push into a full FIFO and a pop from an empty FIFO are both ignored.
module rh11_wfifo #(
    parameter int FIFOLOG2 = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_push,
    input  logic [15:0]         i_wdata,
    input  logic                i_pop,
    output logic [15:0]         o_head,
    output logic                o_full,
    output logic                o_empty,
    output logic [FIFOLOG2:0]   o_count
);
    localparam int DEPTH = 2 ** FIFOLOG2;
    localparam logic [FIFOLOG2-1:0] PTR_ONE = FIFOLOG2'(1'b1);
    localparam logic [FIFOLOG2:0]   CNT_ONE = (FIFOLOG2 + 1)'(1'b1);

    logic [15:0]         r_mem [DEPTH];
    logic [FIFOLOG2-1:0] r_wp;
    logic [FIFOLOG2-1:0] r_rp;
    logic [FIFOLOG2:0]   r_cnt;
    logic                w_push_ok;
    logic                w_pop_ok;

    // Count reaches exactly DEPTH when full, so its MSB is the full flag.
    assign o_full    = r_cnt[FIFOLOG2];
    assign o_empty   = (r_cnt == {(FIFOLOG2 + 1){1'b0}});
    assign o_count   = r_cnt;
    assign o_head    = o_empty ? 16'd0 : r_mem[r_rp];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage array, written without reset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wp] <= i_wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wp  <= {FIFOLOG2{1'b0}};
            r_rp  <= {FIFOLOG2{1'b0}};
            r_cnt <= {(FIFOLOG2 + 1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rp <= r_rp + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/rh11_npr_dma.sv
// Unibus NPR bus master moving RH-11 sector words between PDP memory and the
// ARM-side FIFO, one word per bus tenure.
module rh11_npr_dma #(
    parameter int FIFOLOG2  = 4,
    parameter int SETUPCLKS = 8,
    parameter int NXMCLKS   = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [3:0]  armraddr,
    input  logic [3:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        armintrq,
    input  logic        init_in_h,
    output logic        npr_out_h,
    input  logic        npg_in_h,
    output logic        sack_out_h,
    input  logic        bbsy_in_h,
    output logic        bbsy_out_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    output logic        msyn_out_h,
    input  logic        ssyn_in_h,
    input  logic [15:0] d_in_h
);
    import rh11_pkg::*;

    localparam int SW = (SETUPCLKS > 1) ? $clog2(SETUPCLKS) : 1;
    localparam int NW = (NXMCLKS > 1) ? $clog2(NXMCLKS) : 1;
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUPCLKS - 1);
    localparam logic [SW-1:0] SETUP_ONE  = SW'(1'b1);
    localparam logic [NW-1:0] NXM_LAST   = NW'(NXMCLKS - 1);
    localparam logic [NW-1:0] NXM_ONE    = NW'(1'b1);

    npr_state_e          r_state, w_next;
    logic [17:0]         r_addr;
    logic [15:0]         r_count;
    logic                r_dir, r_busy, r_done, r_nxm, r_ovf;
    logic [SW-1:0]       r_setup_cnt;
    logic [NW-1:0]       r_nxm_cnt;
    logic                r_npr, r_sack, r_bbsy, r_msyn;
    logic [17:0]         r_a;
    logic [1:0]          r_c;
    logic [15:0]         r_d;

    logic                w_dma_push, w_dma_pop, w_step, w_abort, w_finish, w_bus_on;
    logic                w_arm_push, w_arm_pop, w_clr, w_go, w_addr_wr;
    logic                w_fifo_push, w_fifo_pop, w_flush, w_full, w_empty;
    logic [15:0]         w_fifo_wdata, w_head;
    logic [FIFOLOG2:0]   w_count;
    logic [31:0]         w_status;
    logic                w_unused;

    assign w_arm_push   = armwrite && (armwaddr == REG_FIFO) && !armwdata[31];
    assign w_arm_pop    = armwrite && (armwaddr == REG_FIFO) && armwdata[31];
    assign w_clr        = armwrite && (armwaddr == REG_CLR) && armwdata[0];
    assign w_go         = armwrite && (armwaddr == REG_CTRL) && armwdata[31] && !r_busy && !init_in_h;
    assign w_addr_wr    = armwrite && (armwaddr == REG_ADDR) && !r_busy;
    assign w_fifo_push  = w_dma_push | w_arm_push;
    assign w_fifo_pop   = w_dma_pop | w_arm_pop;
    assign w_fifo_wdata = w_dma_push ? d_in_h : armwdata[15:0];
    assign w_flush      = w_clr | init_in_h;
    assign w_bus_on     = (w_next == S_SETUP) || (w_next == S_MSYN) || (w_next == S_WAITS);
    assign w_status     = {r_busy, r_nxm, r_done, r_ovf, w_count, {(11 - FIFOLOG2){1'b0}}, r_count};
    assign w_unused     = ^armwdata[30:18];

    assign armintrq   = r_done | r_nxm;
    assign npr_out_h  = r_npr;
    assign sack_out_h = r_sack;
    assign bbsy_out_h = r_bbsy;
    assign msyn_out_h = r_msyn;
    assign a_out_h    = r_a;
    assign c_out_h    = r_c;
    assign d_out_h    = r_d;

    rh11_wfifo #(.FIFOLOG2(FIFOLOG2)) u_wfifo (
        .i_clk   (CLOCK),
        .i_rst   (RESET),
        .i_flush (w_flush),
        .i_push  (w_fifo_push),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_fifo_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // ARM read mux.
    always_comb begin
        armrdata = 32'd0;
        case (armraddr)
            REG_ID:   armrdata = RH_ID;
            REG_ADDR: armrdata = {14'd0, r_addr};
            REG_CTRL: armrdata = w_status;
            REG_FIFO: armrdata = {15'd0, !w_empty, w_head};
            default:  armrdata = 32'd0;
        endcase
    end

    // Tenure sequencing; INIT overrides everything and returns to IDLE.
    always_comb begin
        w_next     = r_state;
        w_dma_push = 1'b0;
        w_dma_pop  = 1'b0;
        w_step     = 1'b0;
        w_abort    = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_busy && (r_count != 16'd0) && (r_dir ? !w_empty : !w_full)) w_next = S_REQ;
                else w_next = S_IDLE;
            end
            S_REQ: begin
                if (npg_in_h) w_next = S_SACK;
                else w_next = S_REQ;
            end
            S_SACK: begin
                if (!bbsy_in_h && !ssyn_in_h) w_next = S_SETUP;
                else w_next = S_SACK;
            end
            S_SETUP: begin
                if (r_setup_cnt == SETUP_LAST) w_next = S_MSYN;
                else w_next = S_SETUP;
            end
            S_MSYN: begin
                if (ssyn_in_h) begin
                    w_next     = S_WAITS;
                    w_dma_push = !r_dir;
                end else if (r_nxm_cnt == NXM_LAST) begin
                    w_next  = S_RELEASE;
                    w_abort = 1'b1;
                end else begin
                    w_next = S_MSYN;
                end
            end
            S_WAITS: begin
                if (!ssyn_in_h) begin
                    w_next    = S_RELEASE;
                    w_step    = 1'b1;
                    w_dma_pop = r_dir;
                end else begin
                    w_next = S_WAITS;
                end
            end
            S_RELEASE: begin
                w_next   = S_IDLE;
                w_finish = r_busy && (r_count == 16'd0);
            end
            default: w_next = S_IDLE;
        endcase
        if (init_in_h) begin
            w_next     = S_IDLE;
            w_dma_push = 1'b0;
            w_dma_pop  = 1'b0;
            w_step     = 1'b0;
            w_abort    = 1'b0;
            w_finish   = 1'b0;
        end else begin
            w_next = w_next;
        end
    end

    // State register and SETUP / NXM interval counters.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_setup_cnt <= {SW{1'b0}};
            r_nxm_cnt   <= {NW{1'b0}};
        end else begin
            r_state     <= w_next;
            r_setup_cnt <= (r_state == S_SETUP && w_next == S_SETUP) ? r_setup_cnt + SETUP_ONE : {SW{1'b0}};
            r_nxm_cnt   <= (r_state == S_MSYN && w_next == S_MSYN) ? r_nxm_cnt + NXM_ONE : {NW{1'b0}};
        end
    end

    // Bus outputs are decoded from the next state so they change with it.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_npr  <= 1'b0;
            r_sack <= 1'b0;
            r_bbsy <= 1'b0;
            r_msyn <= 1'b0;
            r_a    <= 18'd0;
            r_c    <= C_DATI;
            r_d    <= 16'd0;
        end else begin
            r_npr  <= (w_next == S_REQ);
            r_sack <= (w_next == S_SACK);
            r_bbsy <= w_bus_on;
            r_msyn <= (w_next == S_MSYN);
            r_a    <= w_bus_on ? r_addr : 18'd0;
            r_c    <= (w_bus_on && r_dir) ? C_DATO : C_DATI;
            r_d    <= (w_bus_on && r_dir) ? w_head : 16'd0;
        end
    end

    // Transfer registers and status flags; later assignments take priority.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_addr  <= 18'd0;
            r_count <= 16'd0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nxm   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_clr) begin
                r_done <= 1'b0;
                r_nxm  <= 1'b0;
                r_ovf  <= 1'b0;
            end
            if (w_addr_wr) begin
                r_addr <= {armwdata[17:1], 1'b0};
            end
            if (w_go) begin
                r_dir   <= armwdata[16];
                r_count <= armwdata[15:0];
                if (armwdata[15:0] == 16'd0) r_done <= 1'b1;
                else r_busy <= 1'b1;
            end
            if (w_step) begin
                r_addr  <= r_addr + 18'd2;
                r_count <= r_count - 16'd1;
            end
            if (w_abort) begin
                r_nxm  <= 1'b1;
                r_busy <= 1'b0;
            end
            if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            // A simultaneous ARM and DATI push can store only the bus word.
            if ((w_fifo_push && w_full) || (w_dma_push && w_arm_push)) begin
                r_ovf <= 1'b1;
            end
            if (init_in_h) begin
                r_busy <= 1'b0;
                if (r_msyn) r_nxm <= 1'b1;
            end
        end
    end

endmodule
